// File: rtl/mvm_job_sched.sv
// Round-robin job scheduler in front of a single K x K matrix-vector engine.
// Buffers a whole job, replays it with the engine's load/start protocol, then streams tagged results.
module mvm_job_sched #(
  parameter int K    = 4,
  parameter int B    = 8,
  parameter int NREQ = 2,
  parameter int TMO  = 255,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*B-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*B-1:0]       res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 res_last,
  output logic                 busy,
  output logic                 err,
  output logic                 mvm_reset,
  output logic                 mvm_loadMatrix,
  output logic                 mvm_loadVector,
  output logic                 mvm_start,
  input  logic                 mvm_done,
  output logic [B-1:0]         mvm_data_in,
  input  logic [2*B-1:0]       mvm_data_out
);

  localparam int NW = K * K + K;
  localparam int CW = $clog2(NW + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_CLR, S_LDM, S_MSTR, S_GAP1, S_LDV,
    S_VSTR, S_GAP2, S_START, S_WAIT, S_CAP, S_DRAIN
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_timer;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_clr;
  logic              r_load_m;
  logic              r_load_v;
  logic              r_start;
  logic              r_err;
  logic [B-1:0]      r_data_in;
  logic              r_res_valid;
  logic [2*B-1:0]    r_res_data;
  logic              r_res_last;
  logic [B-1:0]      r_ibuf [NW];
  logic [2*B-1:0]    r_rbuf [K];

  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_id;
  int                w_idx;
  logic              w_in_we;
  logic [B-1:0]      w_req_word;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_req_word = req_data[r_id*B +: B];
  assign w_in_we    = (r_state == S_COLLECT) && req_valid[r_id] && r_req_ready[r_id];
  assign w_cnt_nxt  = r_cnt + CW'(1);

  // Round-robin search starting one past the last granted port.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx     = (int'(r_ptr) + k) % NREQ;
      w_gnt_id  = (!w_gnt_vld && req_valid[w_idx]) ? IDW'(w_idx) : w_gnt_id;
      w_gnt_vld = w_gnt_vld | req_valid[w_idx];
    end
  end

  // Job and result buffers; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_in_we) begin
      r_ibuf[r_cnt] <= w_req_word;
    end
    if (r_state == S_CAP) begin
      r_rbuf[r_cnt] <= mvm_data_out;
    end
  end

  // Scheduler FSM with all control outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_req_ready <= '0;
      r_clr       <= 1'b0;
      r_load_m    <= 1'b0;
      r_load_v    <= 1'b0;
      r_start     <= 1'b0;
      r_err       <= 1'b0;
      r_data_in   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_clr    <= 1'b0;
      r_load_m <= 1'b0;
      r_load_v <= 1'b0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_id        <= w_gnt_id;
            r_ptr       <= w_gnt_id;
            r_cnt       <= '0;
            r_req_ready <= NREQ'(1'b1) << w_gnt_id;
            r_state     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_in_we) begin
            if (r_cnt == CW'(NW - 1)) begin
              r_req_ready <= '0;
              r_clr       <= 1'b1;
              r_state     <= S_CLR;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        S_CLR: begin
          r_load_m <= 1'b1;
          r_state  <= S_LDM;
        end
        S_LDM: begin
          r_data_in <= r_ibuf[0];
          r_cnt     <= '0;
          r_state   <= S_MSTR;
        end
        S_MSTR: begin
          if (r_cnt == CW'(K * K - 1)) begin
            r_state <= S_GAP1;
          end else begin
            r_data_in <= r_ibuf[w_cnt_nxt];
            r_cnt     <= w_cnt_nxt;
          end
        end
        S_GAP1: begin
          r_load_v <= 1'b1;
          r_state  <= S_LDV;
        end
        S_LDV: begin
          r_data_in <= r_ibuf[K * K];
          r_cnt     <= '0;
          r_state   <= S_VSTR;
        end
        S_VSTR: begin
          if (r_cnt == CW'(K - 1)) begin
            r_state <= S_GAP2;
          end else begin
            r_data_in <= r_ibuf[CW'(K * K) + w_cnt_nxt];
            r_cnt     <= w_cnt_nxt;
          end
        end
        S_GAP2: begin
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mvm_done) begin
            r_cnt   <= '0;
            r_state <= S_CAP;
          end else if (r_timer == TW'(TMO - 1)) begin
            // Abort lands in IDLE in the same cycle err and the engine clear are seen.
            r_err   <= 1'b1;
            r_clr   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CAP: begin
          if (r_cnt == CW'(K - 1)) begin
            r_res_valid <= 1'b1;
            r_res_data  <= (K == 1) ? mvm_data_out : r_rbuf[0];
            r_res_last  <= (K == 1);
            r_cnt       <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (r_cnt == CW'(K - 1)) begin
              r_res_valid <= 1'b0;
              r_res_last  <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_res_data <= r_rbuf[w_cnt_nxt];
              r_res_last <= (w_cnt_nxt == CW'(K - 1));
              r_cnt      <= w_cnt_nxt;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;
  assign res_id         = r_id;
  assign res_last       = r_res_last;
  assign busy           = (r_state != S_IDLE);
  assign err            = r_err;
  assign mvm_reset      = reset | r_clr;
  assign mvm_loadMatrix = r_load_m;
  assign mvm_loadVector = r_load_v;
  assign mvm_start      = r_start;
  assign mvm_data_in    = r_data_in;

endmodule

// File: tb/tb_mvm_job_sched.sv
// Scoreboard bench for mvm_job_sched: behavioural engine model, two requester drivers,
// expected results queued at stimulus time and checked by an independent output monitor.
module tb_mvm_job_sched;
  localparam int K = 4, B = 8, NREQ = 2, TMO = 255, LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*B-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic res_valid, res_ready, res_last, busy, err;
  logic [2*B-1:0] res_data;
  logic [0:0] res_id;
  logic mvm_reset, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_done;
  logic [B-1:0] mvm_data_in;
  logic [2*B-1:0] mvm_data_out;

  mvm_job_sched #(.K(K), .B(B), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_last(res_last), .busy(busy),
    .err(err), .mvm_reset(mvm_reset), .mvm_loadMatrix(mvm_loadMatrix),
    .mvm_loadVector(mvm_loadVector), .mvm_start(mvm_start), .mvm_done(mvm_done),
    .mvm_data_in(mvm_data_in), .mvm_data_out(mvm_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];  // {id, last, data}
  task automatic push_exp(input int id, input logic [15:0] y0, y1, y2, y3);
    exp_q.push_back({id[0], 1'b0, y0});
    exp_q.push_back({id[0], 1'b0, y1});
    exp_q.push_back({id[0], 1'b0, y2});
    exp_q.push_back({id[0], 1'b1, y3});
  endtask

  // ---------------- requester drivers ----------------
  logic [7:0] q0[$], q1[$];
  logic [7:0] jm[16], jx[4];
  logic [NREQ-1:0] hs;

  task automatic set_ident();
    for (int i = 0; i < 16; i++) jm[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
  endtask
  task automatic set_x(input logic [7:0] a, b, c, d);
    jx[0] = a; jx[1] = b; jx[2] = c; jx[3] = d;
  endtask
  task automatic load_job(input int p);
    for (int i = 0; i < 20; i++) begin
      if (p == 0) q0.push_back((i < 16) ? jm[i] : jx[i-16]);
      else        q1.push_back((i < 16) ? jm[i] : jx[i-16]);
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) q0.delete(0);
      if (hs[1] && q1.size() > 0) q1.delete(0);
      req_valid[0]   = (q0.size() > 0);
      req_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
      req_valid[1]   = (q1.size() > 0);
      req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // ---------------- engine model ----------------
  logic suppress = 1'b0;
  logic signed [7:0] mat[16], vec[4];
  logic [15:0] ey[4];
  int m_idx = -1, v_idx = -1, o_idx = -1, wait_cnt = 0;
  logic nd, drv;
  logic [15:0] nout;
  int acc;

  initial begin
    mvm_done = 1'b0;
    mvm_data_out = '0;
    nout = '0;
    forever begin
      @(negedge clk);
      nd = 1'b0;
      drv = 1'b0;
      if (mvm_reset) begin
        m_idx = -1; v_idx = -1; o_idx = -1; wait_cnt = 0;
      end else begin
        if (m_idx >= 0) begin
          mat[m_idx] = mvm_data_in;
          m_idx = m_idx + 1;
          if (m_idx == 16) m_idx = -1;
        end
        if (v_idx >= 0) begin
          vec[v_idx] = mvm_data_in;
          v_idx = v_idx + 1;
          if (v_idx == 4) v_idx = -1;
        end
        if (mvm_loadMatrix) m_idx = 0;
        if (mvm_loadVector) v_idx = 0;
        if (o_idx >= 0) begin
          drv = 1'b1;
          nout = ey[o_idx];
          o_idx = o_idx + 1;
          if (o_idx == 4) o_idx = -1;
        end
        if (wait_cnt > 0) begin
          wait_cnt = wait_cnt - 1;
          if (wait_cnt == 0 && !suppress) begin
            nd = 1'b1;
            for (int n = 0; n < 4; n++) begin
              acc = 0;
              for (int j = 0; j < 4; j++) acc = acc + int'(mat[n*4+j]) * int'(vec[j]);
              ey[n] = acc[15:0];
            end
            o_idx = 0;
          end
        end
        if (mvm_start) wait_cnt = LAT;
      end
      @(posedge clk);
      #1;
      mvm_done = nd;
      if (drv) mvm_data_out = nout;
    end
  end

  // ---------------- result ready pattern ----------------
  logic ready_toggle = 1'b0;
  logic [3:0] pat = 4'b1001;
  int pk = 0;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) begin
        res_ready = pat[3-pk];
        pk = (pk + 1) % 4;
      end else begin
        res_ready = 1'b1;
      end
    end
  end

  // ---------------- output monitor ----------------
  int hs_cnt = 0, stall_cnt = 0, rv_cnt = 0, err_cnt = 0;
  int lm_cyc = 0, lv_cyc = 0, start_cyc = 0, err_cyc = 0, lm_run = 0;
  logic stalled = 1'b0, err_mrst, err_busy;
  logic [17:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mvm_loadMatrix) begin
          lm_run++;
          lm_cyc = cyc;
        end else if (lm_run > 0) begin
          chk("loadMatrix_width", lm_run, 1);
          lm_run = 0;
        end
        if (mvm_loadVector) begin
          chk("lm_to_lv_gap", cyc - lm_cyc, 18);
          lv_cyc = cyc;
        end
        if (mvm_start) begin
          chk("lv_to_start_gap", cyc - lv_cyc, 6);
          start_cyc = cyc;
        end
        if (err) begin
          err_cnt++;
          err_cyc = cyc;
          err_mrst = mvm_reset;
          err_busy = busy;
        end
        if (stalled && !res_valid) chk("valid_dropped_while_stalled", res_valid, 1);
        if (res_valid) begin
          rv_cnt++;
          if (exp_q.size() == 0) begin
            chk("res_unexpected_valid", res_valid, 0);
          end else begin
            e = exp_q[0];
            chk("res_data", res_data, e[15:0]);
            chk("res_id", res_id, e[17]);
            chk("res_last", res_last, e[16]);
            if (res_ready) begin
              exp_q.delete(0);
              hs_cnt++;
            end
          end
          if (!res_ready) stall_cnt++;
          stalled = !res_ready;
        end else begin
          stalled = 1'b0;
        end
      end else begin
        lm_run = 0;
        stalled = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int hs0, rv0;
  logic ok;

  initial begin
    reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mvm_reset", mvm_reset, 1);
    chk("rst_err", err, 0);
    chk("rst_ctrl", {mvm_loadMatrix, mvm_loadVector, mvm_start}, 0);
    chk("rst_data_in", mvm_data_in, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Identity job on port 0
    set_ident(); set_x(8'd1, 8'd2, 8'd3, 8'd4);
    push_exp(0, 16'd1, 16'd2, 16'd3, 16'd4);
    load_job(0);
    wait_idle("t1_done", 400);

    // Both ports valid from reset, then port 0 alone (pointer wrap)
    set_x(8'd5, 8'd6, 8'd7, 8'd8);       load_job(0);
    set_x(8'd9, 8'd10, 8'd11, 8'd12);    load_job(1);
    push_exp(0, 16'd5, 16'd6, 16'd7, 16'd8);
    push_exp(1, 16'd9, 16'd10, 16'd11, 16'd12);
    pulse_reset();
    wait_idle("t2_pair_done", 600);
    set_x(8'd13, 8'd14, 8'd15, 8'd16);   load_job(0);
    push_exp(0, 16'd13, 16'd14, 16'd15, 16'd16);
    wait_idle("t2_wrap_done", 400);

    // Fairness: port 0 streams 3 jobs while port 1 streams 2
    pulse_reset();
    set_x(8'd31, 8'd32, 8'd33, 8'd34);   load_job(0);
    set_x(8'd35, 8'd36, 8'd37, 8'd38);   load_job(0);
    set_x(8'd39, 8'd40, 8'd41, 8'd42);   load_job(0);
    set_x(8'd51, 8'd52, 8'd53, 8'd54);   load_job(1);
    set_x(8'd55, 8'd56, 8'd57, 8'd58);   load_job(1);
    push_exp(0, 16'd31, 16'd32, 16'd33, 16'd34);
    push_exp(1, 16'd51, 16'd52, 16'd53, 16'd54);
    push_exp(0, 16'd35, 16'd36, 16'd37, 16'd38);
    push_exp(1, 16'd55, 16'd56, 16'd57, 16'd58);
    push_exp(0, 16'd39, 16'd40, 16'd41, 16'd42);
    wait_idle("t3_rr_done", 1500);

    // Negative data with output back-pressure
    for (int i = 0; i < 16; i++) jm[i] = 8'd2;
    set_x(8'hFF, 8'hFE, 8'hFD, 8'hFC);
    push_exp(0, 16'hFFEC, 16'hFFEC, 16'hFFEC, 16'hFFEC);
    hs0 = hs_cnt;
    stall_cnt = 0;
    ready_toggle = 1'b1;
    load_job(0);
    wait_idle("t4_done", 400);
    ready_toggle = 1'b0;
    chk("t4_handshakes", hs_cnt - hs0, 4);
    chk("t4_stalls_seen", (stall_cnt > 0), 1);

    // Wrapping sums: 4 * 127 * 127 = 64516 = 0xFC04
    for (int i = 0; i < 16; i++) jm[i] = 8'd127;
    set_x(8'd127, 8'd127, 8'd127, 8'd127);
    push_exp(0, 16'hFC04, 16'hFC04, 16'hFC04, 16'hFC04);
    load_job(0);
    wait_idle("t4w_done", 400);

    // Engine never completes: timeout abort
    suppress = 1'b1;
    rv0 = rv_cnt;
    set_ident(); set_x(8'd1, 8'd1, 8'd1, 8'd1);
    load_job(0);
    wait_idle("t5_abort_done", 700);
    suppress = 1'b0;
    chk("t5_err_count", err_cnt, 1);
    chk("t5_err_latency", err_cyc - start_cyc, TMO + 1);
    chk("t5_err_mvm_reset", err_mrst, 1);
    chk("t5_err_busy", err_busy, 0);
    chk("t5_no_results", rv_cnt - rv0, 0);

    // Reset in the middle of the matrix stream
    set_ident(); set_x(8'd9, 8'd9, 8'd9, 8'd9);
    load_job(0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mvm_loadMatrix) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_saw_loadMatrix", ok, 1);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_ctrl_zero", {mvm_loadMatrix, mvm_loadVector, mvm_start, err}, 0);
    chk("t6_mvm_reset", mvm_reset, 1);
    chk("t6_busy", busy, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_data_in", mvm_data_in, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_x(8'd21, 8'd22, 8'd23, 8'd24);   load_job(0);
    set_x(8'd25, 8'd26, 8'd27, 8'd28);   load_job(1);
    push_exp(0, 16'd21, 16'd22, 16'd23, 16'd24);
    push_exp(1, 16'd25, 16'd26, 16'd27, 16'd28);
    wait_idle("t6_after_reset_done", 600);
    chk("final_err_count", err_cnt, 1);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mvm_job_sched.md
Name: mvm_job_sched

Overview:
- Round-robin scheduler that shares one mvm_4_4_8_1 matrix-vector engine between NREQ requesters.
- Each requester streams one job: K*K matrix words in row-major order, then K vector words.
- The block buffers the whole job, replays it into the engine using the engine's load/start protocol, captures the K results after done, and returns them tagged with the requester id over a valid/ready stream.
- It sits between the requester fabric and the MVM instance; it is the only driver of the engine's control pins.

Parameters:
- K, 4, matrix dimension; job = K*K+K input words, K result words
- B, 8, signed input word width; results are 2*B
- NREQ, 2, number of requesters (>=2)
- TMO, 255, maximum cycles in WAIT_DONE before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*B  per-requester word; slice i = bits [i*B +: B]
- req_ready  out  NREQ  per-requester word accept
- res_valid  out  1  result word valid
- res_ready  in  1  result word accept
- res_data  out  2*B  signed result y[n]
- res_id  out  max(1,$clog2(NREQ))  requester that owns the result
- res_last  out  1  high with y[K-1]
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on timeout abort
- mvm_reset  out  1  engine reset; = reset OR internal clear pulse
- mvm_loadMatrix  out  1  engine matrix-load pulse
- mvm_loadVector  out  1  engine vector-load pulse
- mvm_start  out  1  engine start pulse
- mvm_done  in  1  engine completion pulse
- mvm_data_in  out  B  word to engine
- mvm_data_out  in  2*B  engine result

Behaviour:
- Reset (async):
  - state = IDLE; all outputs 0 except mvm_reset = 1 while reset is high.
  - RR pointer = NREQ-1, so port 0 wins the first grant.
  - Buffers are not cleared.
- Engine protocol, fixed:
  - Load pulse in cycle t; word 0 is presented in t+1, word n in t+1+n, with no gaps.
  - After mvm_done rises in cycle D, y[n] appears on mvm_data_out in cycle D+1+n.
  - mvm_data_in is held at the last driven value otherwise.
- IDLE:
  - If any req_valid is set, grant the first valid port searching from pointer+1 (wrapping).
  - Latch the grant id, set pointer = id, go to COLLECT.
- COLLECT:
  - req_ready[id] = 1; all other ready bits are 0.
  - Each req_valid[id] & req_ready[id] stores one word at index cnt, then cnt++.
  - After word K*K+K-1 is stored, go to CLR.
  - Other requesters' valid bits are ignored until the job completes.
- CLR: mvm_reset pulses 1 cycle -> LDM.
- LDM: mvm_loadMatrix = 1 for 1 cycle -> MSTR.
- MSTR: drive matrix words 0..K*K-1, one per cycle -> GAP1 (1 idle cycle).
- LDV: mvm_loadVector = 1 for 1 cycle -> VSTR.
- VSTR: drive vector words 0..K-1 -> GAP2 (1 idle cycle) -> START.
- START: mvm_start = 1 for 1 cycle -> WAIT_DONE; the timer is cleared.
- WAIT_DONE:
  - On mvm_done, go to CAP.
  - If the timer reaches TMO first: pulse err, pulse mvm_reset, go to IDLE with no results and the pointer advanced.
- CAP:
  - Capture mvm_data_out into a K-entry result buffer on the K consecutive cycles after done.
  - No stall is possible, because results are buffered and not forwarded.
  - -> DRAIN.
- DRAIN:
  - res_valid = 1 with res_data = buf[n], res_id = id, res_last = (n == K-1).
  - n advances on res_valid & res_ready.
  - The outputs hold stable while res_ready is low.
  - After the last handshake, go to IDLE.
- Widths and arithmetic:
  - The block does no arithmetic on data; results pass through bit-exact, including wrap.
  - Counters are sized to K*K+K and TMO.
- mvm_done outside WAIT_DONE is ignored.
- Reset mid-job: everything aborts immediately; the partial job is discarded and no results or err are produced.
- Minimum cycles from first accepted word to first res_valid (all valid, done at D): K*K+K + 1 + 1 + K*K + 1 + 1 + K + 1 + 1 + (D wait) + K.

Test Plan:
- Port 0 sends A = identity and x = {1,2,3,4}:
  - mvm_loadMatrix pulses exactly 1 cycle before 16 back-to-back words.
  - Outputs are y = {1,2,3,4} with res_id = 0; res_last only on y=4.
- Both ports valid from reset:
  - port 0 is served first, then port 1 (res_id = 1).
  - Next, port 0 alone is granted again (pointer wrap).
- Port 0 holds req_valid high for 3 consecutive jobs while port 1 requests: grants alternate 0,1,0,1; there is no starvation.
- A = all 2, x = {-1,-2,-3,-4}, res_ready toggling 1-0-0-1: each y = -20 and is held stable while stalled; exactly 4 handshakes.
- The engine model suppresses mvm_done: err pulses exactly TMO+1 cycles after mvm_start, mvm_reset pulses, busy drops, and no res_valid occurs.
- Reset asserted mid-MSTR:
  - All control outputs are 0 immediately, except mvm_reset = 1.
  - A following identity job returns correct results with res_id from the reset grant order (port 0).
